// File: rtl/loadstore.sv
// rtl/loadstore.sv - load/store unit bridging the pipeline to a Wishbone B4 pipelined bus
//
// Purpose: accepts one instruction at a time from the upstream stage. Non-memory
// instructions are forwarded to write-back with one cycle of latency. Memory
// instructions issue a single Wishbone access (byte/half/word, lane-shifted by
// the low address bits) and return the aligned, optionally sign-extended load
// data (or zero for stores) to write-back on completion.
//
// Ports:
//   clk_i, rst_i              clock (rising edge), asynchronous active-low reset
//   input_valid_i/ready_o     upstream handshake
//   result_i                  ALU result or memory byte address
//   ls_enable_i, ls_write_i   memory access enable, store select
//   ls_write_data_i           store data (unshifted, in low lanes)
//   ls_sel_i                  access size: 0001 byte, 0011 half, 1111 word
//   ls_unsigned_load_i        zero-extend sub-word loads
//   reg_write_i, reg_addr_i   destination register write enable / index
//   wb_*                      Wishbone B4 pipelined master
//   output_valid_o, reg_*_o   write-back result (always accepted)
module loadstore (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        input_ready_o,
  input  logic        input_valid_i,
  input  logic [31:0] result_i,
  input  logic        ls_enable_i,
  input  logic        ls_write_i,
  input  logic [31:0] ls_write_data_i,
  input  logic [3:0]  ls_sel_i,
  input  logic        ls_unsigned_load_i,
  input  logic        reg_write_i,
  input  logic [4:0]  reg_addr_i,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  input  logic        wb_stall_i,
  output logic        output_valid_o,
  output logic        reg_write_o,
  output logic [4:0]  reg_addr_o,
  output logic [31:0] reg_data_o
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REQUEST  = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] adr_q, adr_d, dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d, stb_q, stb_d, cyc_q, cyc_d;
  // Captured instruction fields needed at completion.
  logic [1:0]  off_q, off_d;
  logic        word_q, word_d, half_q, half_d, uns_q, uns_d;
  logic        rw_q, rw_d;
  logic [4:0]  ra_q, ra_d;
  // Write-back registers.
  logic        ov_q, ov_d, orw_q, orw_d;
  logic [4:0]  ora_q, ora_d;
  logic [31:0] ord_q, ord_d;

  logic [31:0] ld_shift, ld_data;
  logic        complete;

  assign input_ready_o  = (state_q == ST_IDLE) & rst_i;
  assign wb_adr_o       = adr_q;
  assign wb_dat_o       = dat_q;
  assign wb_sel_o       = sel_q;
  assign wb_we_o        = we_q;
  assign wb_stb_o       = stb_q;
  assign wb_cyc_o       = cyc_q;
  assign output_valid_o = ov_q;
  assign reg_write_o    = orw_q;
  assign reg_addr_o     = ora_q;
  assign reg_data_o     = ord_q;

  // Bring the addressed lane down to bit 0, then size and extend.
  always_comb begin
    ld_shift = wb_dat_i >> {off_q, 3'b000};
    if (word_q)
      ld_data = ld_shift;
    else if (half_q)
      ld_data = {{16{~uns_q & ld_shift[15]}}, ld_shift[15:0]};
    else
      ld_data = {{24{~uns_q & ld_shift[7]}}, ld_shift[7:0]};
  end

  // An ack while the request is still stalled does not count; an ack in the
  // accepting REQUEST cycle completes directly.
  assign complete = ((state_q == ST_REQUEST) & ~wb_stall_i & wb_ack_i) |
                    ((state_q == ST_WAIT_ACK) & wb_ack_i);

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    stb_d   = stb_q;
    cyc_d   = cyc_q;
    off_d   = off_q;
    word_d  = word_q;
    half_d  = half_q;
    uns_d   = uns_q;
    rw_d    = rw_q;
    ra_d    = ra_q;
    ov_d    = 1'b0;
    orw_d   = orw_q;
    ora_d   = ora_q;
    ord_d   = ord_q;
    case (state_q)
      ST_IDLE: begin
        if (input_valid_i) begin
          if (ls_enable_i) begin
            state_d = ST_REQUEST;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            adr_d   = {result_i[31:2], 2'b00};
            we_d    = ls_write_i;
            sel_d   = ls_sel_i << result_i[1:0];
            dat_d   = ls_write_data_i << {result_i[1:0], 3'b000};
            off_d   = result_i[1:0];
            word_d  = ls_sel_i[3];
            half_d  = ls_sel_i[1];
            uns_d   = ls_unsigned_load_i;
            rw_d    = reg_write_i;
            ra_d    = reg_addr_i;
          end else begin
            ov_d  = 1'b1;
            orw_d = reg_write_i;
            ora_d = reg_addr_i;
            ord_d = result_i;
          end
        end
      end
      ST_REQUEST: begin
        if (!wb_stall_i && !wb_ack_i) begin
          state_d = ST_WAIT_ACK;
          stb_d   = 1'b0;
        end
      end
      default: ;
    endcase
    if (complete) begin
      state_d = ST_IDLE;
      cyc_d   = 1'b0;
      stb_d   = 1'b0;
      ov_d    = 1'b1;
      orw_d   = rw_q;
      ora_d   = ra_q;
      ord_d   = we_q ? 32'd0 : ld_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      stb_q   <= 1'b0;
      cyc_q   <= 1'b0;
      off_q   <= '0;
      word_q  <= 1'b0;
      half_q  <= 1'b0;
      uns_q   <= 1'b0;
      rw_q    <= 1'b0;
      ra_q    <= '0;
      ov_q    <= 1'b0;
      orw_q   <= 1'b0;
      ora_q   <= '0;
      ord_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      stb_q   <= stb_d;
      cyc_q   <= cyc_d;
      off_q   <= off_d;
      word_q  <= word_d;
      half_q  <= half_d;
      uns_q   <= uns_d;
      rw_q    <= rw_d;
      ra_q    <= ra_d;
      ov_q    <= ov_d;
      orw_q   <= orw_d;
      ora_q   <= ora_d;
      ord_q   <= ord_d;
    end
  end

endmodule

// File: tb/tb_loadstore.sv
// tb/tb_loadstore.sv - self-checking bench for loadstore
module tb_loadstore;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        input_ready_o;
  logic        input_valid_i = 1'b0;
  logic [31:0] result_i = '0;
  logic        ls_enable_i = 1'b0;
  logic        ls_write_i = 1'b0;
  logic [31:0] ls_write_data_i = '0;
  logic [3:0]  ls_sel_i = 4'b0001;
  logic        ls_unsigned_load_i = 1'b0;
  logic        reg_write_i = 1'b0;
  logic [4:0]  reg_addr_i = '0;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_stb_o, wb_cyc_o;
  logic        wb_ack_i = 1'b0;
  logic        wb_stall_i = 1'b0;
  logic        output_valid_o, reg_write_o;
  logic [4:0]  reg_addr_o;
  logic [31:0] reg_data_o;

  int n_checks = 0;
  int n_fail = 0;

  loadstore dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .input_ready_o(input_ready_o), .input_valid_i(input_valid_i),
    .result_i(result_i), .ls_enable_i(ls_enable_i), .ls_write_i(ls_write_i),
    .ls_write_data_i(ls_write_data_i), .ls_sel_i(ls_sel_i),
    .ls_unsigned_load_i(ls_unsigned_load_i), .reg_write_i(reg_write_i),
    .reg_addr_i(reg_addr_i),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o),
    .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i), .wb_stall_i(wb_stall_i),
    .output_valid_o(output_valid_o), .reg_write_o(reg_write_o),
    .reg_addr_o(reg_addr_o), .reg_data_o(reg_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Load result from the spec's arithmetic: drop low bytes, keep the access
  // width, and subtract 2^width when the top bit is set on a signed load.
  function automatic logic [31:0] load_val(input logic [31:0] d, input int off,
                                           input logic [3:0] sel, input logic uns);
    longint v;
    int nb;
    v  = longint'({32'd0, d});
    v  = v / (longint'(1) << (8 * off));
    nb = (sel == 4'b0001) ? 1 : ((sel == 4'b0011) ? 2 : 4);
    v  = v % (longint'(1) << (8 * nb));
    if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
      v = v - (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  // Behavioural model: one outstanding memory instruction, described as
  // "busy / strobe still pending" plus the captured transaction.
  logic        m_busy, m_stb, m_we, m_uns, m_rw;
  logic [31:0] m_adr, m_dat;
  logic [3:0]  m_sel, m_size;
  logic [4:0]  m_ra;
  int          m_off;
  logic        m_valid, m_orw;
  logic [4:0]  m_ora;
  logic [31:0] m_ord;

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_busy <= 0; m_stb <= 0; m_we <= 0; m_uns <= 0; m_rw <= 0;
      m_adr <= 0; m_dat <= 0; m_sel <= 0; m_size <= 0; m_ra <= 0; m_off <= 0;
      m_valid <= 0; m_orw <= 0; m_ora <= 0; m_ord <= 0;
    end else begin
      m_valid <= 0;
      if (!m_busy) begin
        if (input_valid_i) begin
          if (ls_enable_i) begin
            m_busy <= 1; m_stb <= 1; m_we <= ls_write_i;
            m_off  <= int'(result_i % 4);
            m_adr  <= result_i - (result_i % 4);
            m_sel  <= 4'((int'(ls_sel_i) * (1 << (result_i % 4))) % 16);
            m_dat  <= 32'(64'(ls_write_data_i) * (64'd1 << (8 * (result_i % 4))));
            m_size <= ls_sel_i; m_uns <= ls_unsigned_load_i;
            m_rw   <= reg_write_i; m_ra <= reg_addr_i;
          end else begin
            m_valid <= 1; m_orw <= reg_write_i; m_ora <= reg_addr_i; m_ord <= result_i;
          end
        end
      end else if (wb_ack_i && !(m_stb && wb_stall_i)) begin
        m_busy <= 0; m_stb <= 0; m_valid <= 1; m_orw <= m_rw; m_ora <= m_ra;
        m_ord <= m_we ? 32'd0 : load_val(wb_dat_i, m_off, m_size, m_uns);
      end else if (m_stb && !wb_stall_i) begin
        m_stb <= 0;
      end
    end
  end

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      chk("rst_ready", {31'd0, input_ready_o}, 0);
      chk("rst_valid", {31'd0, output_valid_o}, 0);
      chk("rst_cyc_stb_we", {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 0);
      chk("rst_sel", {28'd0, wb_sel_o}, 0);
      chk("rst_adr", wb_adr_o, 0);
      chk("rst_dat", wb_dat_o, 0);
      chk("rst_reg", {26'd0, reg_write_o, reg_addr_o}, 0);
      chk("rst_data", reg_data_o, 0);
    end else begin
      chk("ready", {31'd0, input_ready_o}, {31'd0, ~m_busy});
      chk("valid", {31'd0, output_valid_o}, {31'd0, m_valid});
      chk("cyc", {31'd0, wb_cyc_o}, {31'd0, m_busy});
      chk("stb", {31'd0, wb_stb_o}, {31'd0, m_stb});
      if (m_valid) begin
        chk("reg_write", {31'd0, reg_write_o}, {31'd0, m_orw});
        chk("reg_addr", {27'd0, reg_addr_o}, {27'd0, m_ora});
        chk("reg_data", reg_data_o, m_ord);
      end
      if (m_busy) begin
        chk("wb_adr", wb_adr_o, m_adr);
        chk("wb_we", {31'd0, wb_we_o}, {31'd0, m_we});
        chk("wb_sel", {28'd0, wb_sel_o}, {28'd0, m_sel});
        chk("wb_dat", wb_dat_o, m_dat);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic issue(input logic en, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] sel,
                       input logic uns, input logic rw, input logic [4:0] ra);
    input_valid_i = 1; ls_enable_i = en; ls_write_i = we; result_i = addr;
    ls_write_data_i = wdata; ls_sel_i = sel; ls_unsigned_load_i = uns;
    reg_write_i = rw; reg_addr_i = ra;
    step();
    input_valid_i = 0;
  endtask

  initial begin
    // Pin the model's load arithmetic with hand-computed values.
    chk("model_byte", load_val(32'h80AABBCC, 3, 4'b0001, 0), 32'hFFFFFF80);
    chk("model_half_u", load_val(32'hBEEF0000, 2, 4'b0011, 1), 32'h0000BEEF);
    chk("model_half_s", load_val(32'hBEEF0000, 2, 4'b0011, 0), 32'hFFFFBEEF);
    chk("model_word", load_val(32'h87654321, 0, 4'b1111, 0), 32'h87654321);

    #1;
    chk("reset_ready", {31'd0, input_ready_o}, 0);
    chk("reset_cyc", {31'd0, wb_cyc_o}, 0);
    step(); step();
    rst_i = 1;
    #1;
    chk("ready_after_release", {31'd0, input_ready_o}, 1);
    step();

    // ALU forward
    issue(0, 0, 32'h12345678, 0, 4'b1111, 0, 1, 5);
    chk("alu_valid", {31'd0, output_valid_o}, 1);
    chk("alu_addr", {27'd0, reg_addr_o}, 5);
    chk("alu_data", reg_data_o, 32'h12345678);
    chk("alu_cyc", {31'd0, wb_cyc_o}, 0);

    // Signed byte load at 0x1003, one stall cycle then ack
    wb_stall_i = 1;
    issue(1, 0, 32'h1003, 0, 4'b0001, 0, 1, 7);
    chk("lb_adr", wb_adr_o, 32'h1000);
    chk("lb_sel", {28'd0, wb_sel_o}, 32'h8);
    chk("lb_stb1", {31'd0, wb_stb_o}, 1);
    step();
    chk("lb_stb2", {31'd0, wb_stb_o}, 1);
    wb_stall_i = 0; wb_ack_i = 1; wb_dat_i = 32'h80AABBCC;
    step();
    wb_ack_i = 0;
    chk("lb_valid", {31'd0, output_valid_o}, 1);
    chk("lb_data", reg_data_o, 32'hFFFFFF80);
    chk("lb_cyc_done", {31'd0, wb_cyc_o}, 0);

    // Half loads at 0x2002, unsigned then signed, acked in the request cycle
    for (int s = 0; s < 2; s++) begin
      issue(1, 0, 32'h2002, 0, 4'b0011, (s == 0), 1, 9);
      chk("lh_sel", {28'd0, wb_sel_o}, 32'hC);
      wb_ack_i = 1; wb_dat_i = 32'hBEEF0000;
      step();
      wb_ack_i = 0;
      chk("lh_data", reg_data_o, (s == 0) ? 32'h0000BEEF : 32'hFFFFBEEF);
    end

    // Store word, ack 3 cycles after the strobe is accepted
    issue(1, 1, 32'h3000, 32'hDEADBEEF, 4'b1111, 0, 0, 3);
    chk("sw_we", {31'd0, wb_we_o}, 1);
    chk("sw_sel", {28'd0, wb_sel_o}, 32'hF);
    chk("sw_dat", wb_dat_o, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sw_ready_low", {31'd0, input_ready_o}, 0);
      chk("sw_no_valid", {31'd0, output_valid_o}, 0);
    end
    wb_ack_i = 1;
    step();
    wb_ack_i = 0;
    chk("sw_valid", {31'd0, output_valid_o}, 1);
    chk("sw_data", reg_data_o, 0);
    step();
    chk("sw_one_pulse", {31'd0, output_valid_o}, 0);

    // Store byte at 0x4001
    issue(1, 1, 32'h4001, 32'h000000AB, 4'b0001, 0, 0, 0);
    chk("sb_sel", {28'd0, wb_sel_o}, 32'h2);
    chk("sb_lane", {24'd0, wb_dat_o[15:8]}, 32'hAB);
    wb_ack_i = 1;
    step();
    wb_ack_i = 0;
    chk("sb_valid", {31'd0, output_valid_o}, 1);

    // Reset during WAIT_ACK, then a late ack
    issue(1, 0, 32'h5000, 0, 4'b1111, 0, 1, 2);
    step();
    chk("wa_stb", {31'd0, wb_stb_o}, 0);
    chk("wa_cyc", {31'd0, wb_cyc_o}, 1);
    rst_i = 0;
    #1;
    chk("wa_rst_cyc", {31'd0, wb_cyc_o}, 0);
    chk("wa_rst_ready", {31'd0, input_ready_o}, 0);
    step();
    rst_i = 1; wb_ack_i = 1;
    #1;
    chk("wa_rel_ready", {31'd0, input_ready_o}, 1);
    step();
    wb_ack_i = 0;
    chk("wa_late_ack", {31'd0, output_valid_o}, 0);
    chk("wa_ready2", {31'd0, input_ready_o}, 1);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      input_valid_i      = ($urandom_range(0, 99) < 60);
      ls_enable_i        = ($urandom_range(0, 99) < 55);
      ls_write_i         = $urandom_range(0, 1);
      result_i           = $urandom;
      ls_write_data_i    = $urandom;
      case ($urandom_range(0, 2))
        0: ls_sel_i = 4'b0001;
        1: ls_sel_i = 4'b0011;
        default: ls_sel_i = 4'b1111;
      endcase
      ls_unsigned_load_i = $urandom_range(0, 1);
      reg_write_i        = $urandom_range(0, 1);
      reg_addr_i         = 5'($urandom);
      wb_stall_i         = ($urandom_range(0, 99) < 30);
      wb_ack_i           = ($urandom_range(0, 99) < 40);
      wb_dat_i           = $urandom;
      if (rst_i && $urandom_range(0, 299) == 0) rst_i = 0;
      else if (!rst_i && $urandom_range(0, 2) == 0) rst_i = 1;
      step();
    end
    rst_i = 1; input_valid_i = 0; wb_ack_i = 0; wb_stall_i = 0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
